// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed seven-segment driver. The scan clock is
// synchronised into CLK_IN, and each rising edge advances the digit index.
// Every digit change is preceded by a dark blanking interval. A full frame
// of VALUE/DP_MASK/LZB is latched at frame start, so the display never tears.
module digit_scan_mux #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    CLK_IN,
   input  logic                    RST,
   input  logic                    SCAN_CLK,
   input  logic [4*NUM_DIGITS-1:0] VALUE,
   input  logic [NUM_DIGITS-1:0]   DP_MASK,
   input  logic                    LZB,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [6:0]              SEG,
   output logic                    DP
);

   localparam int unsigned    IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]     BLANK_LAST = 8'(BLANK_CYCLES);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                  state, state_n;
   logic [7:0]              cnt, cnt_n;
   logic [IDX_W-1:0]        idx;
   logic                    scan_meta, scan_sync, scan_hist;
   logic                    scan_tick;
   logic [4*NUM_DIGITS-1:0] shadow_value;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    shadow_lzb;
   logic [NUM_DIGITS-1:0]   hi_zero;
   logic [3:0]              nib;
   logic                    blank_digit;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [6:0]              seg_n;
   logic                    dp_n;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h3F;
      endcase
   endfunction

   // Two-flop synchroniser plus history flop for edge detection of SCAN_CLK
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         scan_meta <= 1'b0;
         scan_sync <= 1'b0;
         scan_hist <= 1'b0;
      end else begin
         scan_meta <= SCAN_CLK;
         scan_sync <= scan_meta;
         scan_hist <= scan_sync;
      end
   end

   assign scan_tick = scan_sync & ~scan_hist;

   // Digit index advance; the shadow frame is latched as the index wraps to 0
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         idx          <= '0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         shadow_lzb   <= 1'b0;
      end else if (scan_tick) begin
         if (idx == IDX_LAST) begin
            idx          <= '0;
            shadow_value <= VALUE;
            shadow_dp    <= DP_MASK;
            shadow_lzb   <= LZB;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // FSM state and blanking counter registers
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state <= BLANK;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next state: a scan tick always restarts blanking, even mid-blank
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (scan_tick) begin
         state_n = BLANK;
         cnt_n   = '0;
      end else if (state == BLANK) begin
         if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + 8'd1;
         end
      end
   end

   // Leading-zero detection: hi_zero[k] set when nibble k and all above are 0
   always_comb begin
      hi_zero = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         hi_zero[k] = ((shadow_value >> (4 * k)) == '0);
      end
   end

   // Output pattern for the current state and digit
   always_comb begin
      an_n        = '1;
      seg_n       = 7'h7F;
      dp_n        = 1'b1;
      nib         = shadow_value[4*idx +: 4];
      blank_digit = shadow_lzb && (idx != '0) && hi_zero[idx];
      if (state == SHOW) begin
         an_n[idx] = 1'b0;
         seg_n     = blank_digit ? 7'h7F : seg_decode(nib);
         dp_n      = ~shadow_dp[idx];
      end
   end

   // Registered outputs, forced dark asynchronously by reset
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         AN  <= '1;
         SEG <= 7'h7F;
         DP  <= 1'b1;
      end else begin
         AN  <= an_n;
         SEG <= seg_n;
         DP  <= dp_n;
      end
   end

endmodule
